pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_sequencer_next_pc_calc.sv | 41 ++++
 rtl/pc_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding, reset PC and instruction field positions
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TGT_MSB    = 25;
    localparam int TGT_LSB    = 0;
    localparam int REGION_MSB = 31;
    localparam int REGION_LSB = 28;

    localparam int TGT_W = TGT_MSB - TGT_LSB + 1;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// rtl/pc_sequencer_next_pc_calc.sv - combinational next-PC selection (jr > jump > taken branch > pc+4)
module next_pc_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0]      pc_i,
    input  logic [TGT_W-1:0] target_i,
    input  logic             branch_i,
    input  logic             z_flag_i,
    input  logic             jump_i,
    input  logic             jr_i,
    input  logic [31:0]      jr_target_i,
    output logic [31:0]      next_pc_o
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] jr_aligned;
    logic [15:0] imm;

    assign imm        = target_i[IMM_MSB:IMM_LSB];
    assign pc_plus4   = pc_i + 32'd4;
    assign br_offset  = {{14{imm[15]}}, imm, 2'b00};
    assign br_target  = pc_plus4 + br_offset;
    assign jmp_target = {pc_plus4[REGION_MSB:REGION_LSB], target_i, 2'b00};
    // Masking keeps every jr_target bit in the expression; the low two bits are dropped silently.
    assign jr_aligned = jr_target_i & 32'hFFFF_FFFC;

    always_comb begin
        next_pc_o = pc_plus4;
        if (jr_i) begin
            next_pc_o = jr_aligned;
        end else if (jump_i) begin
            next_pc_o = jmp_target;
        end else if (branch_i && z_flag_i) begin
            next_pc_o = br_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/exec program counter sequencer with registered outputs
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        z_flag,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic [31:0] next_pc;
    logic        fetch_accept;
    logic        retire;

    // A fetch completes only while the request is actually being driven.
    assign fetch_accept = (state_q == ST_FETCH) && imem_req_q && imem_ready;
    assign retire       = (state_q == ST_EXEC) && exec_done;

    next_pc_calc u_next_pc_calc (
        .pc_i        (pc_q),
        .target_i    (instr_q[TGT_MSB:TGT_LSB]),
        .branch_i    (branch),
        .z_flag_i    (z_flag),
        .jump_i      (jump),
        .jr_i        (jr),
        .jr_target_i (jr_target),
        .next_pc_o   (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (fetch_accept) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   if (exec_done) state_d = halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Outputs are registered from the upcoming state so each one is valid for the whole cycle.
    always_comb begin
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_DECODE);
        halted_d      = (state_d == ST_HALTED);
        instr_d       = fetch_accept ? imem_rdata : instr_q;
        pc_d          = retire ? next_pc : pc_q;
        retired_d     = retire ? (retired_q + 32'd1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            retired_q     <= 32'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign halted      = halted_q;

endmodule
